// File: rtl/pll_lock_supervisor.sv
// Power-up and lock-loss sequencer for the iCE40 PLL, clocked from the PLL reference clock.
// Holds RESETB, waits for lock, qualifies it over a stability window and retries a bounded number of times.
module pll_lock_supervisor #(
   parameter int RESET_PULSE    = 16,
   parameter int STABLE_CYCLES  = 4096,
   parameter int TIMEOUT_CYCLES = 48000,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       restart,
   output logic       pll_resetb,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retries,
   output logic [7:0] lost_count
);

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } state_t;

   localparam logic [15:0] PULSE_LAST   = 16'(RESET_PULSE - 1);
   localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  retries_q, retries_d;
   logic [7:0]  lost_q, lost_d;
   logic        sync1_q, lock_s_q;

   // locked comes from the PLL analog block, so it is resynchronized before use.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= locked;
         lock_s_q <= sync1_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_HOLD;
         cnt_q     <= 16'd0;
         retries_q <= 4'd0;
         lost_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retries_q <= retries_d;
         lost_q    <= lost_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retries_d = retries_q;
      lost_d    = lost_q;
      if (restart) begin
         // A restart wins over whatever the state would have done this cycle.
         state_d   = ST_HOLD;
         cnt_d     = 16'd0;
         retries_d = 4'd0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (cnt_q == PULSE_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s_q) begin
                  state_d = ST_STABLE;
                  cnt_d   = 16'd0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  retries_d = retries_q + 4'd1;
                  state_d   = (retries_q + 4'd1 == RETRY_LIMIT) ? ST_FAIL : ST_HOLD;
                  cnt_d     = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_STABLE: begin
               // Losing lock inside the window is not counted as a failed attempt.
               if (!lock_s_q) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = 16'd0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d   = ST_RUN;
                  cnt_d     = 16'd0;
                  retries_d = 4'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            ST_RUN: begin
               if (!lock_s_q) begin
                  state_d = ST_HOLD;
                  cnt_d   = 16'd0;
                  if (lost_q != 8'hFF) begin
                     lost_d = lost_q + 8'd1;
                  end
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_HOLD;
               cnt_d   = 16'd0;
            end
         endcase
      end
   end

   assign pll_resetb = (state_q != ST_HOLD) && (state_q != ST_FAIL);
   assign ready      = (state_q == ST_RUN);
   assign fail       = (state_q == ST_FAIL);
   assign retries    = retries_q;
   assign lost_count = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expectations are queued per cycle number
// and compared when the run reaches that cycle (cycle n = value held just before edge n).
module tb_pll_lock_supervisor;

   localparam int RP = 4;
   localparam int SC = 8;
   localparam int TO = 20;
   localparam int MR = 2;

   localparam int S_RSTB = 0;
   localparam int S_RDY  = 1;
   localparam int S_FAIL = 2;
   localparam int S_RETR = 3;
   localparam int S_LOST = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_resetb;
   logic       ready;
   logic       fail;
   logic [3:0] retries;
   logic [7:0] lost_count;

   pll_lock_supervisor #(
      .RESET_PULSE   (RP),
      .STABLE_CYCLES (SC),
      .TIMEOUT_CYCLES(TO),
      .MAX_RETRIES   (MR)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .locked     (locked),
      .restart    (restart),
      .pll_resetb (pll_resetb),
      .ready      (ready),
      .fail       (fail),
      .retries    (retries),
      .lost_count (lost_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cyc;
      int         sig;
      logic [7:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   function automatic logic [7:0] observe(int sig);
      case (sig)
         S_RSTB:  return {7'd0, pll_resetb};
         S_RDY:   return {7'd0, ready};
         S_FAIL:  return {7'd0, fail};
         S_RETR:  return {4'd0, retries};
         default: return lost_count;
      endcase
   endfunction

   task automatic exp_at(int c, int sig, int v, string tag);
      exp_t e;
      e.cyc = c;
      e.sig = sig;
      e.val = 8'(v);
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic exp_range(int c0, int c1, int sig, int v, string tag);
      for (int c = c0; c <= c1; c++) exp_at(c, sig, v, tag);
   endtask

   task automatic check_now(int c);
      exp_t       keep[$];
      logic [7:0] o;
      foreach (sb[i]) begin
         if (sb[i].cyc == c) begin
            o = observe(sb[i].sig);
            checks++;
            assert (o === sb[i].val) else begin
               errors++;
               $error("FAIL %s cyc=%0d observed=%0h expected=%0h", sb[i].tag, c, o, sb[i].val);
            end
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   endtask

   task automatic flush(string scen);
      foreach (sb[i]) begin
         errors++;
         $display("FAIL %s/%s never reached cyc=%0d observed=none expected=%0h",
                  scen, sb[i].tag, sb[i].cyc, sb[i].val);
      end
      sb.delete();
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      check_now(cyc);
   endtask

   task automatic run_until(int n);
      while (cyc < n) tick();
   endtask

   task automatic start_reset(logic lk);
      reset_n = 1'b0;
      locked  = lk;
      restart = 1'b0;
      repeat (3) @(posedge clock);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
      cyc = 0;
      check_now(0);
   endtask

   task automatic exp_s1(string t);
      exp_at(0, S_FAIL, 0, {t, "_rst_fail"});
      exp_at(0, S_RETR, 0, {t, "_rst_retries"});
      exp_at(0, S_LOST, 0, {t, "_rst_lost"});
      exp_range(0, 3, S_RSTB, 0, {t, "_rstb_hold"});
      exp_range(4, 15, S_RSTB, 1, {t, "_rstb_up"});
      exp_range(0, 12, S_RDY, 0, {t, "_ready_low"});
      exp_range(13, 15, S_RDY, 1, {t, "_ready_high"});
      exp_at(13, S_RETR, 0, {t, "_retries_run"});
      exp_at(13, S_FAIL, 0, {t, "_fail_run"});
   endtask

   task automatic async_reset_check(string t);
      #2;
      reset_n = 1'b0;
      #1;
      exp_at(-1, S_RSTB, 0, {t, "_async_rstb"});
      exp_at(-1, S_RDY,  0, {t, "_async_ready"});
      exp_at(-1, S_FAIL, 0, {t, "_async_fail"});
      exp_at(-1, S_RETR, 0, {t, "_async_retries"});
      exp_at(-1, S_LOST, 0, {t, "_async_lost"});
      check_now(-1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Bring-up with lock present from the start.
      start_reset(1'b1);
      exp_s1("s1");
      release_reset();
      run_until(16);
      flush("s1");

      // No lock: two timed-out attempts, then FAIL; restart from FAIL.
      start_reset(1'b0);
      exp_range(0, 3, S_RSTB, 0, "s2_rstb_a");
      exp_range(4, 23, S_RSTB, 1, "s2_rstb_b");
      exp_range(24, 27, S_RSTB, 0, "s2_rstb_c");
      exp_range(28, 47, S_RSTB, 1, "s2_rstb_d");
      exp_range(48, 150, S_RSTB, 0, "s2_rstb_fail");
      exp_at(47, S_FAIL, 0, "s2_fail_pre");
      exp_range(48, 150, S_FAIL, 1, "s2_fail");
      exp_at(30, S_RETR, 1, "s2_retries_1");
      exp_range(48, 150, S_RETR, 2, "s2_retries_2");
      exp_at(151, S_FAIL, 0, "s5_fail_clear");
      exp_at(151, S_RETR, 0, "s5_retries_clear");
      exp_range(151, 154, S_RSTB, 0, "s5_rstb_hold");
      exp_at(155, S_RSTB, 1, "s5_rstb_up");
      exp_at(163, S_RDY, 0, "s5_ready_pre");
      exp_at(164, S_RDY, 1, "s5_ready");
      release_reset();
      run_until(150);
      locked  = 1'b1;
      restart = 1'b1;
      run_until(151);
      restart = 1'b0;
      run_until(166);
      flush("s2");

      // Lock dip in the middle of the stability window.
      start_reset(1'b1);
      exp_range(4, 25, S_RSTB, 1, "s3_rstb");
      exp_range(0, 21, S_RDY, 0, "s3_ready_low");
      exp_range(22, 25, S_RDY, 1, "s3_ready_high");
      exp_at(12, S_RETR, 0, "s3_retries_wait");
      exp_at(22, S_RETR, 0, "s3_retries_run");
      release_reset();
      run_until(8);
      locked = 1'b0;
      run_until(11);
      locked = 1'b1;
      run_until(25);
      flush("s3");

      // Lock loss from RUN, restart in RUN, then drive lost_count into saturation.
      exp_at(32, S_RDY, 1, "s4_ready_pre");
      exp_at(33, S_RDY, 0, "s4_ready_fall");
      exp_at(32, S_RSTB, 1, "s4_rstb_pre");
      exp_range(33, 36, S_RSTB, 0, "s4_rstb_low");
      exp_at(37, S_RSTB, 1, "s4_rstb_up");
      exp_at(32, S_LOST, 0, "s4_lost_pre");
      exp_at(33, S_LOST, 1, "s4_lost_1");
      exp_at(45, S_RDY, 0, "s4_relock_pre");
      exp_at(46, S_RDY, 1, "s4_relock");
      exp_at(50, S_RDY, 1, "s5_run_pre");
      exp_at(51, S_RDY, 0, "s5_run_restart");
      exp_range(51, 54, S_RSTB, 0, "s5_run_rstb");
      exp_range(51, 53, S_LOST, 1, "s5_run_lost");
      exp_at(63, S_RDY, 0, "s5_run_ready_pre");
      exp_at(64, S_RDY, 1, "s5_run_ready");
      for (int k = 0; k < 255; k++) begin
         exp_at(70 + 20 * k + 3, S_LOST, (k + 2 > 255) ? 255 : k + 2, "s4_lost_sat");
      end
      run_until(30);
      locked = 1'b0;
      run_until(33);
      locked = 1'b1;
      run_until(50);
      restart = 1'b1;
      run_until(51);
      restart = 1'b0;
      for (int k = 0; k < 255; k++) begin
         run_until(70 + 20 * k);
         locked = 1'b0;
         run_until(70 + 20 * k + 3);
         locked = 1'b1;
      end
      run_until(70 + 20 * 255);
      flush("s4");

      // Restart on the same edge as the final timeout must win over FAIL.
      start_reset(1'b0);
      exp_at(47, S_RETR, 1, "s5_to_retries_pre");
      exp_at(47, S_RSTB, 1, "s5_to_rstb_pre");
      exp_at(48, S_FAIL, 0, "s5_to_fail");
      exp_at(48, S_RETR, 0, "s5_to_retries");
      exp_range(48, 51, S_RSTB, 0, "s5_to_rstb_hold");
      exp_at(52, S_RSTB, 1, "s5_to_rstb_up");
      exp_at(60, S_FAIL, 0, "s5_to_fail_late");
      release_reset();
      run_until(47);
      restart = 1'b1;
      run_until(48);
      restart = 1'b0;
      run_until(60);
      flush("s5");

      // Asynchronous reset mid-STABLE and mid-RUN, each followed by a clean bring-up.
      start_reset(1'b1);
      exp_at(8, S_RSTB, 1, "s6_stable_rstb");
      release_reset();
      run_until(8);
      async_reset_check("s6_stable");
      repeat (3) @(posedge clock);
      flush("s6a");

      exp_s1("s6b");
      exp_at(19, S_LOST, 1, "s6_lost");
      exp_at(35, S_RDY, 1, "s6_run_ready");
      release_reset();
      run_until(16);
      locked = 1'b0;
      run_until(19);
      locked = 1'b1;
      run_until(35);
      async_reset_check("s6_run");
      repeat (3) @(posedge clock);
      flush("s6b");

      exp_s1("s6c");
      release_reset();
      run_until(16);
      flush("s6c");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
